// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Holds the fetch PC, issues one
// outstanding request at a time on the instruction bus, buffers responses
// in a 2-entry queue and hands them to decode over valid/ready.
// Optional build macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect targets
// become a single exception entry instead of being force-aligned).
//
// state  | meaning
// S_IDLE | no request in flight; waits for queue space
// S_REQ  | request presented at fetch_pc until the bus accepts it
// S_WAIT | request accepted, response will be pushed into the queue
// S_DROP | request accepted before a redirect, response will be discarded
module fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        ireq_ready,
   input  logic        iresp_valid,
   input  logic [31:0] iresp_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_raw_instr,
   output logic [63:0] out_pc,
   output logic        out_misalign
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DROP = 2'd3;

   logic [1:0]  state, state_nxt;
   logic [63:0] fetch_pc;
   logic [63:0] req_pc;
   logic [63:0] redirect_pc_eff;

   logic [31:0] q_instr [2];
   logic [63:0] q_pc    [2];
   logic        q_head, q_tail;
   logic [1:0]  q_count;

   logic        outstanding;
   logic        issue_ok;
   logic        fetch_hold;
   logic        push, pop;
   logic        push_mis;
   logic [63:0] push_pc;
   logic [31:0] push_instr;

   assign outstanding = (state == S_WAIT) || (state == S_DROP);
   assign issue_ok    = ({1'b0, q_count} + {2'b00, outstanding}) < 3'(QDEPTH);

   assign ireq_valid    = (state == S_REQ);
   assign ireq_addr     = fetch_pc;
   assign out_valid     = (q_count != 2'd0);
   assign out_raw_instr = q_instr[q_head];
   assign out_pc        = q_pc[q_head];

   // Redirect discards a same-cycle response and ignores a same-cycle pop.
   assign push = ((state == S_WAIT) && iresp_valid && !redirect_valid) || push_mis;
   assign pop  = out_valid && out_ready && !redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic        mis_pend;
   logic        mis_halt;
   logic [63:0] mis_pc;
   logic        q_mis [2];

   assign redirect_pc_eff = redirect_pc;
   assign fetch_hold      = mis_pend || mis_halt;
   assign push_mis        = mis_pend && !redirect_valid;
   assign push_pc         = push_mis ? mis_pc : req_pc;
   assign push_instr      = push_mis ? 32'h0000_0013 : iresp_data;
   assign out_misalign    = q_mis[q_head];

   // Misaligned redirect: queue one exception entry next cycle, then halt.
   always_ff @(posedge clk) begin
      if (reset) begin
         mis_pend <= 1'b0;
         mis_halt <= 1'b0;
         mis_pc   <= 64'd0;
      end else if (redirect_valid) begin
         mis_pend <= (redirect_pc[1:0] != 2'b00);
         mis_halt <= 1'b0;
         mis_pc   <= redirect_pc;
      end else if (mis_pend) begin
         mis_pend <= 1'b0;
         mis_halt <= 1'b1;
      end
   end

   // Exception flag travels alongside each queue entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_mis[0] <= 1'b0;
         q_mis[1] <= 1'b0;
      end else if (push && !redirect_valid) begin
         q_mis[q_tail] <= push_mis;
      end
   end
`else
   logic unused_pc_lsbs;

   assign unused_pc_lsbs  = ^redirect_pc[1:0];
   assign redirect_pc_eff = {redirect_pc[63:2], 2'b00};
   assign fetch_hold      = 1'b0;
   assign push_mis        = 1'b0;
   assign push_pc         = req_pc;
   assign push_instr      = iresp_data;
   assign out_misalign    = 1'b0;
`endif

   // Next-state decode; redirect outranks every other event.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (!redirect_valid && issue_ok && !fetch_hold) state_nxt = S_REQ;
         S_REQ: begin
            if (redirect_valid) state_nxt = ireq_ready ? S_DROP : S_IDLE;
            else if (ireq_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (redirect_valid) state_nxt = iresp_valid ? S_IDLE : S_DROP;
            else if (iresp_valid) state_nxt = S_IDLE;
         end
         // A response arriving alongside a redirect still retires the drop.
         S_DROP: if (iresp_valid) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register, fetch PC and PC of the accepted request.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         fetch_pc <= RESET_PC;
         req_pc   <= 64'd0;
      end else begin
         state <= state_nxt;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc_eff;
         end else if ((state == S_REQ) && ireq_ready) begin
            fetch_pc <= fetch_pc + 64'd4;
         end
         if ((state == S_REQ) && ireq_ready) req_pc <= fetch_pc;
      end
   end

   // Two-entry circular instruction queue; flushed on redirect.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_head  <= 1'b0;
         q_tail  <= 1'b0;
         q_count <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            q_instr[i] <= 32'd0;
            q_pc[i]    <= 64'd0;
         end
      end else if (redirect_valid) begin
         q_head  <= 1'b0;
         q_tail  <= 1'b0;
         q_count <= 2'd0;
      end else begin
         if (push) begin
            q_instr[q_tail] <= push_instr;
            q_pc[q_tail]    <= push_pc;
            q_tail          <= ~q_tail;
         end
         if (pop) q_head <= ~q_head;
         q_count <= q_count + 2'(push) - 2'(pop);
      end
   end

endmodule
